// File: rtl/core_pkg.sv
// Shared core pipeline types: writeback control bits and the MEM/WB entry layout.
package core_pkg;

  localparam int WB_MEMTOREG = 0;
  localparam int WB_REGWRITE = 1;

  localparam int CORE_DATA_W = 32;
  localparam int CORE_REG_AW = 5;

  typedef logic [1:0] wb_ctrl_t;

  // Field order is shared with the EX/MEM successor; the stage rebuilds it at its own widths.
  typedef struct packed {
    logic                   mem_to_reg;
    logic                   reg_write;
    logic [CORE_DATA_W-1:0] read_data;
    logic [CORE_DATA_W-1:0] alu_result;
    logic [CORE_REG_AW-1:0] dir_write_reg;
  } memwb_entry_t;

endpackage

// File: rtl/memwb_skid_stage_if.sv
// MEM/WB stage bundle: MEM-side inputs, writeback outputs, forwarding tap and retire count.
interface memwb_skid_stage_if
  import core_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  wb_ctrl_t          in_wb;
  logic [DATA_W-1:0] in_read_data;
  logic [DATA_W-1:0] in_alu_result;
  logic [REG_AW-1:0] in_dir_write_reg;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic              mem_to_reg;
  logic              reg_write;
  logic [DATA_W-1:0] read_data;
  logic [DATA_W-1:0] alu_result;
  logic [REG_AW-1:0] dir_write_reg;
  logic [DATA_W-1:0] wb_data;
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_reg;
  logic [DATA_W-1:0] fwd_data;
  logic [CNT_W-1:0]  retire_cnt;

  modport master (
    output in_valid, in_wb, in_read_data, in_alu_result, in_dir_write_reg, flush, out_ready,
    input  in_ready, out_valid, mem_to_reg, reg_write, read_data, alu_result, dir_write_reg,
           wb_data, fwd_valid, fwd_reg, fwd_data, retire_cnt
  );

  modport slave (
    input  in_valid, in_wb, in_read_data, in_alu_result, in_dir_write_reg, flush, out_ready,
    output in_ready, out_valid, mem_to_reg, reg_write, read_data, alu_result, dir_write_reg,
           wb_data, fwd_valid, fwd_reg, fwd_data, retire_cnt
  );
endinterface

// File: rtl/pipe_skid_buf.sv
// Generic one-entry skid buffer: main output register plus one overflow slot, valid/ready on both sides.
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         main_valid, skid_valid;
  logic [W-1:0] main_data, skid_data;
  logic         in_fire, main_free;

  assign in_ready  = !skid_valid;
  assign in_fire   = in_valid && !skid_valid;
  assign main_free = !main_valid || out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      // The skid entry is older than anything on the input, so it drains first.
      if (skid_valid) begin
        main_data  <= skid_data;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (in_fire) begin
        main_data  <= in_data;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_fire) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end
endmodule

// File: rtl/memwb_skid_stage.sv
// MEM/WB pipeline stage: skid-buffered handshake, zero-register write suppression,
// writeback mux, EX forwarding tap and saturating retire counter.
module memwb_skid_stage
  import core_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int REG_AW        = 5,
  parameter int ZERO_SUPPRESS = 1,
  parameter int CNT_W         = 16
) (
  input logic                clk,
  input logic                rst_n,
  memwb_skid_stage_if.slave  bus
);
  typedef struct packed {
    logic              mem_to_reg;
    logic              reg_write;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu_result;
    logic [REG_AW-1:0] dir_write_reg;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  entry_t           in_e, out_e;
  logic             zero_dst, out_valid, out_fire;
  logic [CNT_W-1:0] cnt;

  assign zero_dst = (ZERO_SUPPRESS != 0) && (bus.in_dir_write_reg == '0);

  always_comb begin
    in_e.mem_to_reg    = bus.in_wb[WB_MEMTOREG];
    in_e.reg_write     = bus.in_wb[WB_REGWRITE] && !zero_dst;
    in_e.read_data     = bus.in_read_data;
    in_e.alu_result    = bus.in_alu_result;
    in_e.dir_write_reg = bus.in_dir_write_reg;
  end

  pipe_skid_buf #(.W($bits(entry_t))) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_e),
    .out_valid (out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_e)
  );

  assign out_fire          = out_valid && bus.out_ready;
  assign bus.out_valid     = out_valid;
  assign bus.mem_to_reg    = out_e.mem_to_reg;
  assign bus.reg_write     = out_e.reg_write;
  assign bus.read_data     = out_e.read_data;
  assign bus.alu_result    = out_e.alu_result;
  assign bus.dir_write_reg = out_e.dir_write_reg;
  assign bus.wb_data       = out_e.mem_to_reg ? out_e.read_data : out_e.alu_result;
  assign bus.fwd_valid     = out_valid && out_e.reg_write;
  assign bus.fwd_reg       = out_e.dir_write_reg;
  assign bus.fwd_data      = bus.wb_data;
  assign bus.retire_cnt    = cnt;

  // A flush does not cancel a retirement the register file already accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (out_fire && out_e.reg_write && cnt != CNT_MAX)
      cnt <= cnt + 1'b1;
  end
endmodule

// File: tb/tb_memwb_skid_stage.sv
// Self-checking bench: directed scenarios plus random traffic against a two-deep queue model.
module tb_memwb_skid_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  memwb_skid_stage_if #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) b  ();
  memwb_skid_stage_if #(.DATA_W(32), .REG_AW(5), .CNT_W(4))  b2 ();

  memwb_skid_stage #(.DATA_W(32), .REG_AW(5), .ZERO_SUPPRESS(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b));
  memwb_skid_stage #(.DATA_W(32), .REG_AW(5), .ZERO_SUPPRESS(1), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(b2));

  typedef struct {
    bit          m2r;
    bit          rw;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  dir;
  } ent_t;

  ent_t m_q[$];
  int   m_cnt = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [1:0] wb, input logic [31:0] rd,
                       input logic [31:0] alu, input logic [4:0] dir, input bit fl, input bit ordy);
    b.in_valid = v; b.in_wb = wb; b.in_read_data = rd; b.in_alu_result = alu;
    b.in_dir_write_reg = dir; b.flush = fl; b.out_ready = ordy;
  endtask

  // Reference: the stage holds up to two instructions in arrival order.
  task automatic model_edge();
    bit   ofire, ifire;
    ent_t e;
    ofire = (m_q.size() > 0) && b.out_ready;
    ifire = b.in_valid && (m_q.size() < 2);
    if (ofire && m_q[0].rw && m_cnt < 65535) m_cnt++;
    if (b.flush) m_q.delete();
    else begin
      if (ofire) void'(m_q.pop_front());
      if (ifire) begin
        e.m2r = b.in_wb[0];
        e.rw  = b.in_wb[1] && (b.in_dir_write_reg != 0);
        e.rd  = b.in_read_data;
        e.alu = b.in_alu_result;
        e.dir = b.in_dir_write_reg;
        m_q.push_back(e);
      end
    end
  endtask

  task automatic check_all();
    chk("out_valid", b.out_valid, m_q.size() > 0);
    chk("in_ready", b.in_ready, m_q.size() < 2);
    chk("retire_cnt", b.retire_cnt, m_cnt);
    if (m_q.size() > 0) begin
      chk("mem_to_reg", b.mem_to_reg, m_q[0].m2r);
      chk("reg_write", b.reg_write, m_q[0].rw);
      chk("read_data", b.read_data, m_q[0].rd);
      chk("alu_result", b.alu_result, m_q[0].alu);
      chk("dir_write_reg", b.dir_write_reg, m_q[0].dir);
      chk("wb_data", b.wb_data, m_q[0].m2r ? m_q[0].rd : m_q[0].alu);
      chk("fwd_valid", b.fwd_valid, m_q[0].rw);
      chk("fwd_reg", b.fwd_reg, m_q[0].dir);
      chk("fwd_data", b.fwd_data, m_q[0].m2r ? m_q[0].rd : m_q[0].alu);
    end else begin
      chk("fwd_valid_idle", b.fwd_valid, 1'b0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int cnt_before;
    drive(0, 2'b00, 0, 0, 0, 0, 1);
    b2.in_valid = 0; b2.in_wb = 2'b10; b2.in_read_data = 0; b2.in_alu_result = 0;
    b2.in_dir_write_reg = 5'd1; b2.flush = 0; b2.out_ready = 1;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", b.out_valid, 1'b0);
    chk("rst_in_ready", b.in_ready, 1'b1);
    chk("rst_retire", b.retire_cnt, 0);
    chk("rst_read_data", b.read_data, 0);
    chk("rst_wb_data", b.wb_data, 0);
    rst_n = 1'b1;

    // Stream of four, one per cycle
    drive(1, 2'b10, 32'h0, 32'h0000_0010, 5'd3, 0, 1);
    step();
    chk("stream0_wb_data", b.wb_data, 32'h10);
    chk("stream0_reg_write", b.reg_write, 1'b1);
    drive(1, 2'b11, 32'h55, 32'h20, 5'd4, 0, 1); step();
    chk("stream1_wb_data", b.wb_data, 32'h55);
    drive(1, 2'b10, 32'h66, 32'h30, 5'd5, 0, 1); step();
    chk("stream2_wb_data", b.wb_data, 32'h30);
    drive(1, 2'b10, 32'h77, 32'h40, 5'd6, 0, 1); step();
    chk("stream3_wb_data", b.wb_data, 32'h40);
    drive(0, 2'b00, 0, 0, 0, 0, 1); step();
    chk("stream_retire", b.retire_cnt, 4);

    // Stall: A then B fill main and skid
    drive(1, 2'b10, 0, 32'hAAAA, 5'd1, 0, 0); step();
    drive(1, 2'b10, 0, 32'hBBBB, 5'd2, 0, 0); step();
    chk("stall_in_ready", b.in_ready, 1'b0);
    drive(1, 2'b10, 0, 32'hCCCC, 5'd3, 0, 0); step();
    chk("stall_hold_A", b.alu_result, 32'hAAAA);
    drive(0, 2'b00, 0, 0, 0, 0, 1); step();
    chk("release_B", b.alu_result, 32'hBBBB);
    step();
    chk("release_empty", b.out_valid, 1'b0);
    chk("release_retire", b.retire_cnt, 6);

    // Zero-register suppression
    cnt_before = m_cnt;
    drive(1, 2'b11, 32'h1234, 32'h9, 5'd0, 0, 1); step();
    chk("zero_reg_write", b.reg_write, 1'b0);
    chk("zero_fwd_valid", b.fwd_valid, 1'b0);
    drive(1, 2'b11, 32'hDEAD_BEEF, 32'h9, 5'd7, 0, 1); step();
    chk("zero_retire_same", b.retire_cnt, cnt_before);
    chk("dead_wb_data", b.wb_data, 32'hDEAD_BEEF);
    chk("dead_fwd_reg", b.fwd_reg, 5'd7);
    drive(0, 2'b00, 0, 0, 0, 0, 1); step();

    // Flush with both entries held and a new input presented
    drive(1, 2'b10, 0, 32'h1111, 5'd1, 0, 0); step();
    drive(1, 2'b10, 0, 32'h2222, 5'd2, 0, 0); step();
    cnt_before = m_cnt;
    drive(1, 2'b10, 0, 32'h3333, 5'd3, 1, 0); step();
    chk("flush_out_valid", b.out_valid, 1'b0);
    chk("flush_in_ready", b.in_ready, 1'b1);
    chk("flush_retire", b.retire_cnt, cnt_before);
    drive(0, 2'b00, 0, 0, 0, 0, 1); step(); step();
    chk("flush_gone", b.out_valid, 1'b0);

    // Asynchronous reset between edges while stalled
    drive(1, 2'b10, 0, 32'h4444, 5'd4, 0, 0); step();
    drive(1, 2'b10, 0, 32'h5555, 5'd5, 0, 0); step();
    drive(0, 2'b00, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", b.out_valid, 1'b0);
    chk("arst_in_ready", b.in_ready, 1'b1);
    chk("arst_retire", b.retire_cnt, 0);
    m_q.delete();
    m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 2'b00, 0, 0, 0, 0, 1);
    step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, 2'($urandom), $urandom, $urandom, 5'($urandom % 8),
            ($urandom % 25) == 0, ($urandom % 3) != 0);
      step();
    end
    drive(0, 2'b00, 0, 0, 0, 0, 1);
    step(); step();

    // Saturation on the 4-bit counter instance
    b2.in_valid = 1;
    for (int i = 1; i <= 17; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("sat_progress", b2.retire_cnt, (i - 1 > 15) ? 15 : i - 1);
    end
    b2.in_valid = 0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("sat_final", b2.retire_cnt, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/memwb_skid_stage.md
Name: memwb_skid_stage

Overview:
- Parametrised MEM/WB pipeline stage for the 5-stage core; successor to the plain MEM/WB latch.
- Adds valid/ready handshake, a one-entry skid buffer so a stalled writeback port does not drop MEM results, synchronous flush, and zero-register write suppression.
- Also adds a registered writeback-data mux, a forwarding tap toward EX, and a saturating retire counter.
- Sits between the data-memory stage and the register-file write port.

Parameters:
- DATA_W, 32, width of read_data / alu_result / wb_data
- REG_AW, 5, register address width
- ZERO_SUPPRESS, 1, 1 = force reg_write low when write address is 0
- CNT_W, 16, retire counter width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  MEM stage presents an instruction
- in_ready  out  1  stage can accept (registered, = !skid_valid)
- in_wb  in  2  bit0 MemtoReg, bit1 RegWrite
- in_read_data  in  DATA_W  data-memory read value
- in_alu_result  in  DATA_W  ALU result
- in_dir_write_reg  in  REG_AW  destination register
- flush  in  1  discard all held entries
- out_valid  out  1  main register holds an instruction
- out_ready  in  1  register-file port accepts this cycle
- mem_to_reg  out  1  held MemtoReg
- reg_write  out  1  held RegWrite, after zero suppression
- read_data  out  DATA_W  held read data
- alu_result  out  DATA_W  held ALU result
- dir_write_reg  out  REG_AW  held destination
- wb_data  out  DATA_W  mem_to_reg ? read_data : alu_result (from registered fields)
- fwd_valid  out  1  out_valid & reg_write
- fwd_reg  out  REG_AW  = dir_write_reg
- fwd_data  out  DATA_W  = wb_data
- retire_cnt  out  CNT_W  handshaken instructions with reg_write=1

Behaviour:
- Reset (async, rst_n=0): main_valid=0, skid_valid=0, all data fields 0, retire_cnt=0, so in_ready=1 and out_valid=0. Release is synchronous to clk.
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Data outputs are don't-care when out_valid=0, but they hold their last value and never glitch to X.
- Zero suppression: the stored reg_write bit is in_wb[1] & (in_dir_write_reg != 0) when ZERO_SUPPRESS=1, else in_wb[1].
- Latency:
  - The captured entry appears on the outputs 1 cycle after in_fire when the main register is free.
  - Throughput is 1/cycle while out_ready=1.
- Per-edge update (no flush):
  - Main empty or out_fire, skid_valid=1: main <= skid, skid_valid <= 0.
    - An in_fire cannot coincide here, because in_ready=0 whenever skid_valid=1.
  - Main empty or out_fire, skid_valid=0, in_fire: main <= input, main_valid <= 1.
  - Main empty or out_fire, no source: main_valid <= 0.
  - Main full, no out_fire, in_fire: skid <= input, skid_valid <= 1.
  - Otherwise: hold.
- Order preservation: the skid entry is always older than any new input and always drains first.
- Flush:
  - Next edge: main_valid <= 0, skid_valid <= 0.
  - An input with in_fire in the same cycle is discarded.
  - An out_fire in the same cycle still counts as retired, since the consumer already accepted it.
  - Data fields are not cleared.
- retire_cnt:
  - Increments on out_fire & reg_write.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - Reset-only clear.
- Reset mid-operation: all entries are lost immediately, including a pending skid entry.

Decomposition:
- Shared package core_pkg:
  - WB bit indices WB_MEMTOREG=0, WB_REGWRITE=1.
  - Typedef wb_ctrl_t (2 bits).
  - Typedef memwb_entry_t {mem_to_reg, reg_write, read_data, alu_result, dir_write_reg}, shared with the EX/MEM successor.
- One natural sub-module: pipe_skid_buf, a generic-width valid/ready skid buffer of one payload vector.
  - memwb_skid_stage instantiates it with the packed entry.
  - The wb_data mux, forwarding tap and counter stay outside the sub-module.

Test Plan:
- Reset then stream 4 instructions, out_ready=1: each appears 1 cycle after input. E.g. alu_result=0x0000_0010, wb=2'b10, dir=3 -> wb_data=0x10, reg_write=1; retire_cnt ends at 4.
- Hold out_ready=0 with 2 inputs A, B: in_ready drops after B enters the skid. Releasing out_ready yields A, then B, in order, with no loss and no duplicate.
- Input wb=2'b11, dir=0, ZERO_SUPPRESS=1: reg_write=0, fwd_valid=0, retire_cnt unchanged. With dir=7, read_data=0xDEAD_BEEF: wb_data=0xDEADBEEF, fwd_reg=7.
- Main and skid full, pulse flush with in_valid=1: next cycle out_valid=0, in_ready=1, flushed input never appears, retire_cnt unchanged.
- Assert rst_n=0 asynchronously mid-stall between edges: out_valid and in_ready respond immediately (0 and 1), retire_cnt=0.
- CNT_W=4, 17 retiring writes: retire_cnt saturates at 15.
